// File: rtl/irq_vec_pkg.sv
// irq_vec_pkg
//   Shared definitions for the vectored interrupt controller: Avalon word
//   addresses of the register map, FSM state encoding and VECTOR register
//   bit positions.
package irq_vec_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_PENDING  = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_VECTOR   = 3'd3;
    localparam logic [2:0] ADDR_CLAIM    = 3'd4;
    localparam logic [2:0] ADDR_EOI      = 3'd5;
    localparam logic [2:0] ADDR_POLARITY = 3'd6;

    localparam int unsigned VEC_ACTIVE_BIT  = 31;
    localparam int unsigned VEC_SERVICE_BIT = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync
//   Per-source synchroniser and edge detector. Three flops bring the raw line
//   into the clk domain; s2/s3 are compared to produce a one-cycle pulse on
//   the selected edge.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   in_line    in   raw asynchronous interrupt line
//   polarity   in   0 = rising edge, 1 = falling edge
//   level      out  synchronised level (s2 stage)
//   pulse      out  edge pulse, combinational from s2/s3
module irq_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic in_line,
    input  logic polarity,
    output logic level,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_line;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign pulse = polarity ? (~s2 & s3) : (s2 & ~s3);

endmodule

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl
//   Memory-mapped vectored interrupt controller. Edge-detected sources latch
//   pending bits; enabled pending sources are arbitrated round-robin and one
//   vector at a time is presented to the CPU, which sequences service with
//   CLAIM and EOI writes.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   Avalon word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   in_port     in   raw interrupt lines, one per source
//   readdata    out  registered read data
//   irq         out  CPU interrupt request (level)
module irq_vector_ctrl
    import irq_vec_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [N_SRC-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    irq_state_e state;
    irq_state_e state_next;

    logic [N_SRC-1:0] level;
    logic [N_SRC-1:0] edge_vec;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] polarity;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] claim_clr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_next;

    logic wr_en;
    logic wr_pending;
    logic wr_mask;
    logic wr_claim;
    logic wr_eoi;
    logic wr_polarity;

    logic load_id;
    logic claim_ok;
    logic eoi_ok;
    logic drop;

    assign wr_en       = chipselect & ~write_n;
    assign wr_pending  = wr_en && (address == ADDR_PENDING);
    assign wr_mask     = wr_en && (address == ADDR_MASK);
    assign wr_claim    = wr_en && (address == ADDR_CLAIM);
    assign wr_eoi      = wr_en && (address == ADDR_EOI);
    assign wr_polarity = wr_en && (address == ADDR_POLARITY);

    if (N_SRC < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:N_SRC];
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_edge_sync u_sync (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_line  (in_port[g]),
            .polarity (polarity[g]),
            .level    (level[g]),
            .pulse    (edge_vec[g])
        );
    end

    assign cand = pending & mask;

    // Round-robin pick: rotate cand so rr_ptr lands at bit 0, take the lowest
    // set bit, then add rr_ptr back modulo N_SRC.
    logic [N_SRC-1:0] cand_rot;
    logic [ID_W-1:0]  first_rot;
    logic [ID_W:0]    pick_sum;
    logic [ID_W-1:0]  pick_id;

    always_comb begin
        cand_rot  = N_SRC'({cand, cand} >> rr_ptr);
        first_rot = '0;
        for (int unsigned k = N_SRC; k > 0; k--) begin
            if (cand_rot[k-1]) begin
                first_rot = ID_W'(k - 1);
            end
        end
        pick_sum = {1'b0, first_rot} + {1'b0, rr_ptr};
        if (pick_sum >= (ID_W+1)'(N_SRC)) begin
            pick_sum = pick_sum - (ID_W+1)'(N_SRC);
        end
        pick_id = pick_sum[ID_W-1:0];
    end

    assign rr_next = (cur_id == ID_W'(N_SRC - 1)) ? '0 : cur_id + 1'b1;

    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        claim_ok   = 1'b0;
        eoi_ok     = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (|cand) begin
                    state_next = PRESENT;
                    load_id    = 1'b1;
                end
            end
            PRESENT: begin
                // Losing the candidate (masked or cleared) takes precedence
                // over a claim arriving in the same cycle.
                if (!cand[cur_id]) begin
                    state_next = IDLE;
                    drop       = 1'b1;
                end else if (wr_claim) begin
                    state_next = SERVICE;
                    claim_ok   = 1'b1;
                end
            end
            SERVICE: begin
                if (wr_eoi && (writedata[ID_W-1:0] == cur_id)) begin
                    state_next = IDLE;
                    eoi_ok     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            irq   <= 1'b0;
        end else begin
            state <= state_next;
            irq   <= (state_next == PRESENT);
        end
    end

    // cur_id returns to 0 whenever the FSM goes back to IDLE so that VECTOR
    // reads as all-zero while nothing is presented or in service.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_id <= '0;
            rr_ptr <= '0;
        end else begin
            if (load_id) begin
                cur_id <= pick_id;
            end else if (drop || eoi_ok) begin
                cur_id <= '0;
            end
            if (eoi_ok) begin
                rr_ptr <= rr_next;
            end
        end
    end

    assign w1c_clr   = wr_pending ? writedata[N_SRC-1:0] : '0;
    assign claim_clr = claim_ok ? (N_SRC'(1) << cur_id) : '0;

    // A fresh edge wins over any clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            mask     <= '0;
            polarity <= '0;
        end else begin
            pending <= (pending & ~w1c_clr & ~claim_clr) | edge_vec;
            if (wr_mask) begin
                mask <= writedata[N_SRC-1:0];
            end
            if (wr_polarity) begin
                polarity <= writedata[N_SRC-1:0];
            end
        end
    end

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_STATUS:   rd_mux[N_SRC-1:0] = level;
            ADDR_PENDING:  rd_mux[N_SRC-1:0] = pending;
            ADDR_MASK:     rd_mux[N_SRC-1:0] = mask;
            ADDR_VECTOR: begin
                rd_mux[VEC_ACTIVE_BIT]  = (state != IDLE);
                rd_mux[VEC_SERVICE_BIT] = (state == SERVICE);
                rd_mux[ID_W-1:0]        = cur_id;
            end
            ADDR_POLARITY: rd_mux[N_SRC-1:0] = polarity;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= chipselect ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
module tb_irq_vector_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    irq_vector_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: pending/mask/polarity as bit vectors, the input
    // history as a delay line, the controller mode as 0/1/2.
    logic [7:0] m_hist[3];
    logic [7:0] m_pend, m_mask, m_pol;
    int         m_st, m_cur, m_rr;
    logic [7:0] cur_in = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_pend = '0; m_mask = '0; m_pol = '0;
        m_st = 0; m_cur = 0; m_rr = 0;
    endtask

    task automatic model_step(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [31:0] wd, input logic [7:0] inp,
                              output logic [31:0] erd, output logic eirq);
        bit wr, claim, eoi, found, now_b, prev_b;
        logic [7:0] cand, e, w1c, cclr;
        logic [31:0] r;
        int n_st, n_cur, n_rr, b;
        wr    = cs && !wn;
        claim = wr && (a == 3'd4);
        eoi   = wr && (a == 3'd5);
        r = 0;
        case (a)
            3'd0: r = {24'd0, m_hist[1]};
            3'd1: r = {24'd0, m_pend};
            3'd2: r = {24'd0, m_mask};
            3'd3: r = ((m_st != 0) ? 32'h8000_0000 : 0) | ((m_st == 2) ? 32'h4000_0000 : 0) | m_cur;
            3'd6: r = {24'd0, m_pol};
            default: r = 0;
        endcase
        erd = cs ? r : 32'd0;
        for (int i = 0; i < 8; i++) begin
            now_b  = m_hist[1][i];
            prev_b = m_hist[2][i];
            e[i] = m_pol[i] ? (prev_b && !now_b) : (!prev_b && now_b);
        end
        cand = m_pend & m_mask;
        n_st = m_st; n_cur = m_cur; n_rr = m_rr; cclr = '0;
        if (m_st == 0) begin
            if (cand != 0) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    b = (m_rr + k) % 8;
                    if (!found && cand[b]) begin
                        found = 1;
                        n_cur = b;
                    end
                end
                n_st = 1;
            end
        end else if (m_st == 1) begin
            if (!cand[m_cur]) begin
                n_st = 0; n_cur = 0;
            end else if (claim) begin
                cclr[m_cur] = 1'b1;
                n_st = 2;
            end
        end else begin
            if (eoi && (wd[2:0] == 3'(m_cur))) begin
                n_rr = (m_cur + 1) % 8;
                n_st = 0; n_cur = 0;
            end
        end
        w1c = (wr && a == 3'd1) ? wd[7:0] : 8'd0;
        m_pend = (m_pend & ~w1c & ~cclr) | e;
        if (wr && a == 3'd2) m_mask = wd[7:0];
        if (wr && a == 3'd6) m_pol = wd[7:0];
        m_st = n_st; m_cur = n_cur; m_rr = n_rr;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = inp;
        eirq = (n_st == 1);
    endtask

    task automatic drive(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] wd, input string nm,
                         input bit hc, input logic [31:0] cv);
        logic [31:0] erd;
        logic eirq;
        exp_t e;
        @(negedge clk);
        chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = cur_in;
        model_step(cs, wn, a, wd, cur_in, erd, eirq);
        e.rd = hc ? cv : erd;
        e.irq = eirq;
        e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic idle();                                  drive(0, 1, 3'd0, 0, "idle", 0, 0); endtask
    task automatic rd(input logic [2:0] a);                 drive(1, 1, a, 0, "rd", 0, 0);      endtask
    task automatic rdc(input logic [2:0] a, input logic [31:0] v, input string nm); drive(1, 1, a, 0, nm, 1, v); endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d); drive(1, 0, a, d, "wr", 0, 0); endtask
    task automatic idles(input int n); for (int i = 0; i < n; i++) idle(); endtask

    task automatic do_reset();
        @(negedge clk);
        chipselect = 0; write_n = 1; address = 0; writedata = 0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: one expected entry per driven cycle, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check({e.nm, "_rd"}, readdata, e.rd);
                check({e.nm, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        int r, bit_i;
        logic [31:0] d;
        model_reset();
        repeat (3) @(negedge clk);
        check("init_rst_readdata", readdata, 32'd0);
        check("init_rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        rdc(3'd0, 0, "rst_status");
        rdc(3'd1, 0, "rst_pending");
        rdc(3'd2, 0, "rst_mask");
        rdc(3'd3, 0, "rst_vector");
        rdc(3'd6, 0, "rst_polarity");

        // Single rising edge on source 2, then claim/EOI.
        wr(3'd2, 32'hFF);
        cur_in = 8'h04;
        idle(); idle();
        rdc(3'd1, 32'h0, "t1_pend_before");
        rdc(3'd1, 32'h4, "t1_pend_set");
        rdc(3'd3, 32'h8000_0002, "t1_vector");
        wr(3'd4, 0);
        rdc(3'd3, 32'hC000_0002, "t2_vector_service");
        rdc(3'd1, 32'h0, "t2_pend_claimed");
        wr(3'd5, 2);
        rdc(3'd3, 32'h0, "t2_vector_idle");

        // Sources 1 and 5 together with rr_ptr at 3.
        cur_in = 8'h26;
        idles(4);
        rdc(3'd3, 32'h8000_0005, "t3_first_id5");
        wr(3'd4, 0);
        wr(3'd5, 5);
        idle();
        rdc(3'd3, 32'h8000_0001, "t3_then_id1");
        wr(3'd4, 0);
        wr(3'd5, 1);

        // Mask a presented vector before claim, then unmask.
        cur_in = 8'h36;
        idles(4);
        rdc(3'd3, 32'h8000_0004, "t4_present_id4");
        wr(3'd2, 32'hEF);
        idle();
        rdc(3'd3, 32'h0, "t4_dropped");
        wr(3'd2, 32'hFF);
        idle();
        rdc(3'd3, 32'h8000_0004, "t4_represent");
        wr(3'd4, 0);
        wr(3'd5, 4);

        // Polarity: rise ignored with falling select, fall taken.
        wr(3'd6, 32'h01);
        cur_in = 8'h37;
        idles(3);
        rdc(3'd1, 32'h0, "t5_rise_ignored");
        cur_in = 8'h36;
        idles(3);
        rdc(3'd1, 32'h1, "t5_fall_pending");
        rdc(3'd3, 32'h8000_0000, "t5_vector_id0");
        wr(3'd4, 0);
        wr(3'd5, 0);
        cur_in = 8'h37;
        idles(3);
        wr(3'd6, 32'h00);
        cur_in = 8'h36;
        idles(3);
        rdc(3'd1, 32'h0, "t5_fall_ignored");
        // W1C coinciding with a new edge.
        wr(3'd2, 32'h00);
        cur_in = 8'h37;
        idle(); idle();
        wr(3'd1, 32'h01);
        rdc(3'd1, 32'h1, "t5_w1c_edge_wins");
        wr(3'd1, 32'hFF);
        rdc(3'd1, 32'h0, "t5_w1c_clear");
        wr(3'd2, 32'hFF);

        // Mismatched EOI, then reset in SERVICE.
        cur_in = 8'h33;
        idles(3);
        cur_in = 8'h37;
        idles(4);
        rdc(3'd3, 32'h8000_0002, "t6_present_id2");
        wr(3'd4, 0);
        wr(3'd5, 32'hFFFF_FFF3);
        rdc(3'd3, 32'hC000_0002, "t6_bad_eoi_ignored");
        rd(3'd3);
        do_reset();
        rdc(3'd1, 32'h0, "t6_pend_after_rst");
        rdc(3'd2, 32'h0, "t6_mask_after_rst");
        rdc(3'd3, 32'h0, "t6_vector_after_rst");
        rdc(3'd6, 32'h0, "t6_pol_after_rst");

        // Randomised traffic against the model.
        wr(3'd2, 32'hFF);
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                do_reset();
                wr(3'd2, $urandom());
            end
            if ($urandom_range(0, 3) == 0) begin
                bit_i = $urandom_range(0, 7);
                cur_in[bit_i] = ~cur_in[bit_i];
            end
            r = $urandom_range(0, 99);
            d = $urandom();
            if (r < 20)      idle();
            else if (r < 42) rd(3'($urandom_range(0, 7)));
            else if (r < 50) wr(3'd2, ($urandom_range(0, 3) == 0) ? d : (d | 32'hFF));
            else if (r < 57) wr(3'd1, d);
            else if (r < 61) wr(3'd6, d);
            else if (r < 72) wr(3'd4, d);
            else if (r < 84) wr(3'd5, ($urandom_range(0, 1) == 0) ? {d[31:3], 3'(m_cur)} : d);
            else if (r < 90) wr(3'($urandom_range(0, 1) == 0 ? 0 : ($urandom_range(0, 1) == 0 ? 3 : 7)), d);
            else             idle();
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
